// File: rtl/loader_pkg.sv
// Shared types and constants for the SRAM program loader.
package loader_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;

  // Opcode in bits [15:12] that terminates a program.
  localparam logic [3:0] OPC_END = 4'b0000;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StWaitHi = 3'd1;
  localparam state_t StWaitLo = 3'd2;
  localparam state_t StSetup  = 3'd3;
  localparam state_t StWrite  = 3'd4;
  localparam state_t StHold   = 3'd5;
  localparam state_t StFinish = 3'd6;

endpackage

// File: rtl/sram_write_port.sv
// Sequences one asynchronous SRAM write: setup, WE low, hold.
// Address and data are captured on go and stay constant for the whole write.
module sram_write_port
  import loader_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned WE_LOW_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   go,
  input  logic [SRAM_ADDR_W-1:0] addr,
  input  logic [SRAM_DATA_W-1:0] data,
  output logic [SRAM_ADDR_W-1:0] sram_a,
  output logic [SRAM_DATA_W-1:0] sram_d,
  output logic                   we_n,
  output logic                   drive,
  output logic                   done
);

  localparam logic [7:0] SetupLd = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] WeLd    = 8'(WE_LOW_CYCLES - 1);
  localparam logic [7:0] HoldLd  = 8'(HOLD_CYCLES - 1);

  state_t                 phase_q, phase_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [SRAM_ADDR_W-1:0] a_q, a_d;
  logic [SRAM_DATA_W-1:0] d_q, d_d;

  // Phase sequencing with a down-counter; done pulses in the last hold cycle.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    d_d     = d_q;
    done    = 1'b0;
    case (phase_q)
      StIdle: begin
        if (go) begin
          phase_d = StSetup;
          cnt_d   = SetupLd;
          a_d     = addr;
          d_d     = data;
        end
      end
      StSetup: begin
        if (cnt_q == 8'd0) begin
          phase_d = StWrite;
          cnt_d   = WeLd;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StWrite: begin
        if (cnt_q == 8'd0) begin
          phase_d = StHold;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHold: begin
        if (cnt_q == 8'd0) begin
          phase_d = StIdle;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: phase_d = StIdle;
    endcase
  end

  // Phase, counter and captured bus values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q <= StIdle;
      cnt_q   <= 8'd0;
      a_q     <= '0;
      d_q     <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      d_q     <= d_d;
    end
  end

  assign sram_a = a_q;
  assign sram_d = d_q;
  assign we_n   = (phase_q != StWrite);
  assign drive  = (phase_q != StIdle);

endmodule

// File: rtl/sram_loader.sv
// Loads a UART byte stream into SRAM as 16-bit words (high byte first),
// stopping after the END word or when the address space is exhausted.
module sram_loader
  import loader_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned WE_LOW_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [7:0]             RX_DATA,
  input  logic                   RX_VALID,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERROR,
  output logic [SRAM_ADDR_W-1:0] WORD_COUNT,
  output logic                   SRAM_WE,
  output logic                   SRAM_CE,
  output logic                   SRAM_OE,
  output logic                   SRAM_LB,
  output logic                   SRAM_UB,
  output logic [SRAM_ADDR_W-1:0] SRAM_A,
  output logic [SRAM_DATA_W-1:0] SRAM_D_OUT,
  output logic                   SRAM_D_DRIVE
);

  localparam logic [SRAM_ADDR_W-1:0] AddrMax = '1;

  state_t                 state_q, state_d;
  logic [7:0]             hi_q, hi_d;
  logic [3:0]             opc_q, opc_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_ADDR_W-1:0] count_q, count_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   go;
  logic                   wp_done;

  // Byte assembly, END/overflow detection, counters and sticky flags.
  // StSetup covers the whole write; the write port sequences its phases.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    opc_d   = opc_q;
    addr_d  = addr_q;
    count_d = count_q;
    done_d  = done_q;
    error_d = error_q;
    go      = 1'b0;
    case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StWaitHi;
          done_d  = 1'b0;
          error_d = 1'b0;
          count_d = '0;
          addr_d  = '0;
        end
      end
      StWaitHi: begin
        if (RX_VALID) begin
          hi_d    = RX_DATA;
          opc_d   = RX_DATA[7:4];
          state_d = StWaitLo;
        end
      end
      StWaitLo: begin
        if (RX_VALID) begin
          go      = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (RX_VALID) error_d = 1'b1;
        if (wp_done) begin
          count_d = count_q + 1'b1;
          if (addr_q != AddrMax) addr_d = addr_q + 1'b1;
          if (opc_q == OPC_END) begin
            state_d = StFinish;
          end else if (addr_q == AddrMax) begin
            error_d = 1'b1;
            state_d = StFinish;
          end else begin
            state_d = StWaitHi;
          end
        end
      end
      StFinish: begin
        if (RX_VALID) error_d = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Loader state and flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      hi_q    <= 8'd0;
      opc_q   <= 4'd0;
      addr_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      opc_q   <= opc_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  sram_write_port #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .WE_LOW_CYCLES(WE_LOW_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) u_wp (
    .CLK   (CLK),
    .RST   (RST),
    .go    (go),
    .addr  (addr_q),
    .data  ({hi_q, RX_DATA}),
    .sram_a(SRAM_A),
    .sram_d(SRAM_D_OUT),
    .we_n  (SRAM_WE),
    .drive (SRAM_D_DRIVE),
    .done  (wp_done)
  );

  assign BUSY       = (state_q != StIdle);
  assign DONE       = done_q;
  assign ERROR      = error_q;
  assign WORD_COUNT = count_q;
  assign SRAM_OE    = BUSY;
  assign SRAM_CE    = 1'b0;
  assign SRAM_LB    = 1'b0;
  assign SRAM_UB    = 1'b0;

endmodule

// File: tb/tb_sram_loader.sv
// Randomized bench for sram_loader with a cycle-timing reference model.
module tb_sram_loader;

  localparam int S = 1;
  localparam int W = 2;
  localparam int H = 1;
  localparam int L = S + W + H;
  localparam logic [17:0] AMAX = 18'h3FFFF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  RX_DATA = 8'd0;
  logic        RX_VALID = 1'b0;
  logic        BUSY, DONE, ERROR;
  logic [17:0] WORD_COUNT;
  logic        SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB;
  logic [17:0] SRAM_A;
  logic [15:0] SRAM_D_OUT;
  logic        SRAM_D_DRIVE;

  sram_loader #(
    .SETUP_CYCLES (S),
    .WE_LOW_CYCLES(W),
    .HOLD_CYCLES  (H)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .RX_DATA     (RX_DATA),
    .RX_VALID    (RX_VALID),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERROR       (ERROR),
    .WORD_COUNT  (WORD_COUNT),
    .SRAM_WE     (SRAM_WE),
    .SRAM_CE     (SRAM_CE),
    .SRAM_OE     (SRAM_OE),
    .SRAM_LB     (SRAM_LB),
    .SRAM_UB     (SRAM_UB),
    .SRAM_A      (SRAM_A),
    .SRAM_D_OUT  (SRAM_D_OUT),
    .SRAM_D_DRIVE(SRAM_D_DRIVE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Events recorded by the stimulus, consumed by the model.
  int          rst_last  = -100;
  int          start_cyc = -100;
  int          err_cyc   = -100;
  int          cur_t     = -100;
  logic [17:0] cur_addr  = '0;
  logic [15:0] cur_data  = '0;
  logic        cur_last  = 1'b0;
  logic        cur_ovf   = 1'b0;
  logic [17:0] next_addr = '0;

  logic [15:0] mem     [int];
  logic [15:0] exp_mem [int];

  // Model expectations derived from event times.
  logic        armed = 1'b0;
  logic        exp_done = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
  logic [17:0] exp_count = '0, exp_a = '0;
  logic [15:0] exp_d = '0;
  logic        prev_we = 1'b1;

  always @(negedge CLK) begin
    int   c;
    logic in_win, exp_we;
    c = cyc;
    if (c == rst_last + 1) begin
      armed = 1'b1; exp_done = 0; exp_err = 0; exp_busy = 0;
      exp_count = '0; exp_a = '0; exp_d = '0; cur_t = -100;
    end
    if (c == start_cyc + 1) begin
      exp_done = 0; exp_err = 0; exp_count = '0; exp_busy = 1;
    end
    if (c == cur_t + 1) begin
      exp_a = cur_addr; exp_d = cur_data;
    end
    if (c == cur_t + L + 1) begin
      exp_count = exp_count + 1'b1;
      if (cur_ovf) exp_err = 1;
    end
    if (c == cur_t + L + 2 && cur_last) begin
      exp_done = 1; exp_busy = 0;
    end
    if (c == err_cyc) exp_err = 1;
    in_win = (c >= cur_t + 1) && (c <= cur_t + L);
    exp_we = !((c >= cur_t + 1 + S) && (c <= cur_t + S + W));
    if (armed) begin
      chk("we", 32'(SRAM_WE), 32'(exp_we));
      chk("drive", 32'(SRAM_D_DRIVE), 32'(in_win));
      chk("addr", 32'(SRAM_A), 32'(exp_a));
      chk("data", 32'(SRAM_D_OUT), 32'(exp_d));
      chk("busy", 32'(BUSY), 32'(exp_busy));
      chk("oe", 32'(SRAM_OE), 32'(exp_busy));
      chk("done", 32'(DONE), 32'(exp_done));
      chk("error", 32'(ERROR), 32'(exp_err));
      chk("count", 32'(WORD_COUNT), 32'(exp_count));
      chk("ce_lb_ub", 32'({SRAM_CE, SRAM_LB, SRAM_UB}), 32'd0);
      if (!prev_we && SRAM_WE) mem[int'(SRAM_A)] = SRAM_D_OUT;
    end
    prev_we = SRAM_WE;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic with_rx);
    mem.delete();
    exp_mem.delete();
    START = 1; RX_VALID = with_rx; RX_DATA = 8'hA5;
    start_cyc = cyc; next_addr = '0;
    tick();
    START = 0; RX_VALID = 0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap, input logic stray);
    RX_DATA = w[15:8]; RX_VALID = 1;
    tick();
    RX_VALID = 0;
    repeat (gap) tick();
    RX_DATA = w[7:0]; RX_VALID = 1;
    cur_addr = next_addr;
    cur_data = w;
    cur_ovf  = (w[15:12] != 4'h0) && (next_addr == AMAX);
    cur_last = (w[15:12] == 4'h0) || cur_ovf;
    cur_t    = cyc;
    exp_mem[int'(next_addr)] = w;
    if (next_addr != AMAX) next_addr = next_addr + 1'b1;
    tick();
    RX_VALID = 0;
    if (stray) begin
      repeat (S) tick();
      RX_DATA = 8'($urandom); RX_VALID = 1; err_cyc = cyc + 1;
      tick();
      RX_VALID = 0;
      repeat (L + 2 - S) tick();
    end else begin
      repeat (L + 3) tick();
    end
  endtask

  task automatic check_mem();
    foreach (exp_mem[k]) begin
      chk("mem", mem.exists(k) ? 32'(mem[k]) : 32'hFFFF_FFFF, 32'(exp_mem[k]));
    end
  endtask

  initial begin
    logic [15:0] w;
    repeat (3) begin
      rst_last = cyc;
      tick();
    end
    RST = 0;
    chk("rst_we", 32'(SRAM_WE), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_count", 32'(WORD_COUNT), 32'd0);

    // Byte in IDLE is ignored; then START with a coincident byte.
    RX_DATA = 8'h33; RX_VALID = 1; tick(); RX_VALID = 0;
    repeat (2) tick();
    do_start(1'b1);

    send_word(16'h801F, 2, 1'b0);
    send_word(16'h1060, 0, 1'b0);
    send_word(16'h0000, 3, 1'b0);
    tick();
    chk("plan_mem0", mem.exists(0) ? 32'(mem[0]) : 32'hFFFF_FFFF, 32'h801F);
    chk("plan_mem1", mem.exists(1) ? 32'(mem[1]) : 32'hFFFF_FFFF, 32'h1060);
    chk("plan_mem2", mem.exists(2) ? 32'(mem[2]) : 32'hFFFF_FFFF, 32'h0000);
    chk("plan_done", 32'(DONE), 32'd1);
    chk("plan_count", 32'(WORD_COUNT), 32'd3);
    chk("plan_busy", 32'(BUSY), 32'd0);

    // Random load with stray bytes and an ignored mid-load START.
    do_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      w = {4'($urandom_range(1, 15)), 12'($urandom)};
      send_word(w, $urandom_range(0, 4), (i == 1) || ($urandom_range(0, 3) == 0));
      if (i == 3) begin
        START = 1; tick(); START = 0;
      end
    end
    send_word({4'h0, 12'($urandom)}, 1, 1'b0);
    tick();
    check_mem();
    chk("rand_count", 32'(WORD_COUNT), 32'd9);
    chk("rand_error", 32'(ERROR), 32'd1);

    // Reset while WE is low.
    do_start(1'b0);
    RX_DATA = 8'h45; RX_VALID = 1; tick(); RX_VALID = 0;
    RX_DATA = 8'h67; RX_VALID = 1;
    cur_addr = '0; cur_data = 16'h4567; cur_ovf = 0; cur_last = 0; cur_t = cyc;
    tick();
    RX_VALID = 0;
    repeat (S) tick();
    chk("mid_we_low", 32'(SRAM_WE), 32'd0);
    RST = 1; rst_last = cyc;
    tick();
    RST = 0;
    chk("rstw_we", 32'(SRAM_WE), 32'd1);
    chk("rstw_drive", 32'(SRAM_D_DRIVE), 32'd0);
    chk("rstw_a", 32'(SRAM_A), 32'd0);
    chk("rstw_busy", 32'(BUSY), 32'd0);
    repeat (2) tick();
    do_start(1'b0);
    send_word(16'h0123, 1, 1'b0);
    tick();
    chk("restart_mem0", mem.exists(0) ? 32'(mem[0]) : 32'hFFFF_FFFF, 32'h0123);
    chk("restart_count", 32'(WORD_COUNT), 32'd1);

    // Overflow at the top address.
    do_start(1'b0);
    send_word(16'h1111, 0, 1'b0);
    force dut.addr_q = AMAX;
    tick();
    release dut.addr_q;
    next_addr = AMAX;
    send_word(16'h2222, 2, 1'b0);
    repeat (3) tick();
    chk("ovf_mem", mem.exists(int'(AMAX)) ? 32'(mem[int'(AMAX)]) : 32'hFFFF_FFFF, 32'h2222);
    chk("ovf_mem0", mem.exists(0) ? 32'(mem[0]) : 32'hFFFF_FFFF, 32'h1111);
    chk("ovf_error", 32'(ERROR), 32'd1);
    chk("ovf_done", 32'(DONE), 32'd1);
    chk("ovf_count", 32'(WORD_COUNT), 32'd2);
    chk("ovf_we", 32'(SRAM_WE), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
